// File: rtl/seg_clock_pkg.sv
// Shared definitions for the hh:mm:ss timekeeping slice: mode encodings,
// field limits, blank-mask bit positions and modulo step helpers.
package seg_clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_e;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  localparam int BLK_SEC_LO  = 0;
  localparam int BLK_SEC_HI  = 1;
  localparam int BLK_MIN_LO  = 2;
  localparam int BLK_MIN_HI  = 3;
  localparam int BLK_HOUR_LO = 4;
  localparam int BLK_HOUR_HI = 5;

  // +1 modulo (max_val+1); out-of-range inputs fold back to 0
  function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max_val);
    if (val >= max_val) begin
      return 6'd0;
    end else begin
      return val + 6'd1;
    end
  endfunction

  // -1 modulo (max_val+1); out-of-range inputs fold back to max_val
  function automatic logic [5:0] wrap_dec(input logic [5:0] val, input logic [5:0] max_val);
    if ((val == 6'd0) || (val > max_val)) begin
      return max_val;
    end else begin
      return val - 6'd1;
    end
  endfunction

endpackage

// File: rtl/seg_blink_gen.sv
// Blink phase generator for the field being edited. A prescaler divides clk
// down to twice the blink rate and the phase toggles at each terminal count.
// restart forces prescaler and phase back to 0 so an edit is shown at once.
module seg_blink_gen #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  output logic phase
);

  localparam int PRESC = CLK_FREQ / (2 * BLINK_HZ);
  localparam int CW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CW-1:0] TC = CW'(PRESC - 1);

  logic [CW-1:0] cnt_r;
  logic          phase_r;

  // Prescaler count and phase toggle, with synchronous restart
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (restart) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (cnt_r == TC) begin
      cnt_r   <= '0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
      phase_r <= phase_r;
    end
  end

  assign phase = phase_r;

endmodule

// File: rtl/seg_time_ctrl.sv
// Timekeeping and time-set controller for the 6-digit hh:mm:ss display.
// Holds hour/min/sec, advances them on tick_1s while running, and runs the
// key-driven set-mode FSM with auto-timeout and a blinking edit field.
module seg_time_ctrl
  import seg_clock_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BLINK_HZ  = 2,
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick_1s,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [5:0] blank,
  output logic [1:0] mode,
  output logic       day_pulse
);

  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_S - 1);

  mode_e         mode_r;
  mode_e         mode_nx_s;
  logic [4:0]    hour_r, hour_nx_s;
  logic [5:0]    min_r, min_nx_s;
  logic [5:0]    sec_r, sec_nx_s;
  logic          day_r, day_nx_s;
  logic [TW-1:0] to_cnt_r, to_cnt_nx_s;
  logic [5:0]    blank_s;
  logic          in_set_s;
  logic          key_any_s;
  logic          edit_s;
  logic          timeout_s;
  logic          enter_set_s;
  logic          restart_s;
  logic          phase_s;

  assign in_set_s    = (mode_r != MODE_RUN);
  assign key_any_s   = key_mode | key_inc | key_dec;
  // A mode key always wins over inc/dec; inc together with dec cancels out
  assign edit_s      = in_set_s & ~key_mode & (key_inc ^ key_dec);
  // The timeout fires on the tick that would bring the count to TIMEOUT_S
  assign timeout_s   = in_set_s & tick_1s & ~key_any_s & (to_cnt_r == TO_LAST);
  // Every mode key except the one leaving SET_SEC lands in a SET_* state
  assign enter_set_s = key_mode & (mode_r != MODE_SET_SEC);
  assign restart_s   = enter_set_s | edit_s;

  seg_blink_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BLINK_HZ (BLINK_HZ)
  ) u_blink (
    .clk     (clk),
    .rstn    (rstn),
    .restart (restart_s),
    .phase   (phase_s)
  );

  // Mode FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_r <= MODE_RUN;
    end else begin
      mode_r <= mode_nx_s;
    end
  end

  // Mode FSM next state: key_mode cycles the modes, timeout drops back to RUN
  always_comb begin
    mode_nx_s = mode_r;
    case (mode_r)
      MODE_RUN: begin
        if (key_mode) mode_nx_s = MODE_SET_HOUR;
        else          mode_nx_s = MODE_RUN;
      end
      MODE_SET_HOUR: begin
        if (key_mode)       mode_nx_s = MODE_SET_MIN;
        else if (timeout_s) mode_nx_s = MODE_RUN;
        else                mode_nx_s = MODE_SET_HOUR;
      end
      MODE_SET_MIN: begin
        if (key_mode)       mode_nx_s = MODE_SET_SEC;
        else if (timeout_s) mode_nx_s = MODE_RUN;
        else                mode_nx_s = MODE_SET_MIN;
      end
      MODE_SET_SEC: begin
        if (key_mode)       mode_nx_s = MODE_RUN;
        else if (timeout_s) mode_nx_s = MODE_RUN;
        else                mode_nx_s = MODE_SET_SEC;
      end
      default: mode_nx_s = MODE_RUN;
    endcase
  end

  // Mode FSM outputs: blank mask is a direct decode of the mode and phase flops
  always_comb begin
    blank_s = 6'b000000;
    case (mode_r)
      MODE_SET_HOUR: begin
        blank_s[BLK_HOUR_HI] = phase_s;
        blank_s[BLK_HOUR_LO] = phase_s;
      end
      MODE_SET_MIN: begin
        blank_s[BLK_MIN_HI] = phase_s;
        blank_s[BLK_MIN_LO] = phase_s;
      end
      MODE_SET_SEC: begin
        blank_s[BLK_SEC_HI] = phase_s;
        blank_s[BLK_SEC_LO] = phase_s;
      end
      default: blank_s = 6'b000000;
    endcase
  end

  // Timeout counter next value: cleared by keys, outside set mode and on expiry
  always_comb begin
    if (!in_set_s || key_any_s || timeout_s) begin
      to_cnt_nx_s = '0;
    end else if (tick_1s) begin
      to_cnt_nx_s = to_cnt_r + TW'(1);
    end else begin
      to_cnt_nx_s = to_cnt_r;
    end
  end

  // Time next value: ripple-carry count in RUN, single-field modulo edit in SET_*
  always_comb begin
    hour_nx_s = hour_r;
    min_nx_s  = min_r;
    sec_nx_s  = sec_r;
    day_nx_s  = 1'b0;
    if ((mode_r == MODE_RUN) && tick_1s) begin
      sec_nx_s = wrap_inc(sec_r, SEC_MAX);
      if (sec_r == SEC_MAX) begin
        min_nx_s = wrap_inc(min_r, MIN_MAX);
        if (min_r == MIN_MAX) begin
          hour_nx_s = 5'(wrap_inc({1'b0, hour_r}, HOUR_MAX));
          day_nx_s  = ({1'b0, hour_r} == HOUR_MAX);
        end else begin
          hour_nx_s = hour_r;
        end
      end else begin
        min_nx_s = min_r;
      end
    end else if (edit_s) begin
      case (mode_r)
        MODE_SET_HOUR: begin
          if (key_inc) hour_nx_s = 5'(wrap_inc({1'b0, hour_r}, HOUR_MAX));
          else         hour_nx_s = 5'(wrap_dec({1'b0, hour_r}, HOUR_MAX));
        end
        MODE_SET_MIN: begin
          if (key_inc) min_nx_s = wrap_inc(min_r, MIN_MAX);
          else         min_nx_s = wrap_dec(min_r, MIN_MAX);
        end
        MODE_SET_SEC: begin
          if (key_inc) sec_nx_s = wrap_inc(sec_r, SEC_MAX);
          else         sec_nx_s = wrap_dec(sec_r, SEC_MAX);
        end
        default: begin
          hour_nx_s = hour_r;
        end
      endcase
    end else begin
      day_nx_s = 1'b0;
    end
  end

  // Time, day pulse and timeout registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hour_r   <= 5'd0;
      min_r    <= 6'd0;
      sec_r    <= 6'd0;
      day_r    <= 1'b0;
      to_cnt_r <= '0;
    end else begin
      hour_r   <= hour_nx_s;
      min_r    <= min_nx_s;
      sec_r    <= sec_nx_s;
      day_r    <= day_nx_s;
      to_cnt_r <= to_cnt_nx_s;
    end
  end

  assign hour      = hour_r;
  assign min       = min_r;
  assign sec       = sec_r;
  assign day_pulse = day_r;
  assign mode      = mode_r;
  assign blank     = blank_s;

endmodule
